xgriscv_run_ctrl: RTL and testbench
===================================

Name: xgriscv_run_ctrl

Overview:
- Run/halt sequencer wrapped around the single-cycle core `xgriscv_sc`.
- Accepts a program as a valid/ready word stream and writes it into the instruction memory write port, starting at word 0.
- Holds the core in reset while loading, releases it, and counts cycles while it runs.
- Stops the run when the PC reaches a halt address or a cycle budget expires, then reports status, final PC and cycle count.

Parameters:
ADDR_SIZE, 32, width of PC and data words
IMEM_AW, 8, imem word-address width (capacity 2^IMEM_AW words)
HALT_PC, 32'h80000078, PC value that signals program end
MAX_CYCLES, 100, run-cycle budget before timeout (>=1)
RESET_HOLD, 2, cycles core reset stays asserted after load completes (>=1)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begin load; honoured in IDLE and HALT only
abort  in  1  synchronous abort to IDLE from any state
ld_valid  in  1  program word valid
ld_data  in  ADDR_SIZE  program word
ld_last  in  1  marks final program word
ld_ready  out  1  controller accepts a word this cycle
imem_we  out  1  imem write enable
imem_waddr  out  IMEM_AW  imem word address
imem_wdata  out  ADDR_SIZE  imem write data
cpu_rstn  out  1  active-low reset to core
cpu_pc  in  ADDR_SIZE  core PC
busy  out  1  state is LOAD, HOLD or RUN
done  out  1  sticky: halted on HALT_PC
timeout  out  1  sticky: halted on budget expiry
ovf  out  1  sticky: program exceeded imem capacity
final_pc  out  ADDR_SIZE  cpu_pc captured on entry to HALT from RUN
cycle_count  out  32  run cycles counted

Behaviour:
- States: IDLE, LOAD, HOLD, RUN, HALT.
- Reset (rstn=0, async) values:
  - state=IDLE, cpu_rstn=0, ld_ready=0, imem_we=0.
  - imem_waddr=0, imem_wdata=0.
  - done=timeout=ovf=0, final_pc=0, cycle_count=0, busy=0.
- Reset mid-operation: same values immediately. Any partial imem content is left as-is.
- cpu_rstn=1 only in RUN. It is 0 in every other state.
- IDLE/HALT:
  - On start: clear done/timeout/ovf/cycle_count/final_pc, load word counter=0, go LOAD next cycle.
  - Without start: remain.
- LOAD: ld_ready=1.
  - Handshake (ld_valid&ld_ready) is combinational: imem_we=1, imem_waddr=word counter, imem_wdata=ld_data, all in the same cycle.
  - Counter increments after each handshake.
  - No handshake: imem_we=0, counter holds.
  - Handshake with ld_last=1: go HOLD, load hold counter=RESET_HOLD-1.
  - Handshake at counter=2^IMEM_AW-1 with ld_last=0: word is written, ovf=1, go HALT. Counter never wraps; final_pc=0.
  - A single-word program (ld_last on first word) is legal.
- HOLD: cpu_rstn=0, ld_ready=0. Hold counter decrements; at 0, go RUN. HOLD therefore lasts exactly RESET_HOLD cycles.
- RUN: cycle_count increments by 1 each cycle in RUN, including the exit cycle.
  - Exit when cpu_pc==HALT_PC: done=1.
  - Exit when cycle_count+1==MAX_CYCLES: timeout=1.
  - Both true in the same cycle: done=1, timeout=0.
  - On exit: final_pc<=cpu_pc, go HALT.
- HALT: status, final_pc and cycle_count hold until the next start, abort or reset.
- abort=1: go IDLE next cycle with cpu_rstn=0. Status flags and counters hold (not cleared). Abort has priority over start and all exit conditions.
- start in LOAD/HOLD/RUN is ignored.
- Outputs done/timeout/ovf/final_pc/cycle_count are registered. ld_ready, imem_we and busy are decoded from state.

Test Plan:
- Load 3 words (0x00000013 x2, last 0x0000006f), ld_valid held → imem writes at addr 0,1,2 on consecutive cycles. HOLD lasts 2 cycles with cpu_rstn=0, then cpu_rstn=1.
- RUN with cpu_pc stepping from 0x80000000 by 4 each cycle → at cpu_pc=0x80000078: done=1, timeout=0, final_pc=0x80000078, cycle_count=31, cpu_rstn=0 next cycle.
- cpu_pc stuck at 0x80000010 → timeout=1, done=0, cycle_count=100 after the 100th RUN cycle.
- Stream 256 words with no ld_last, IMEM_AW=8 → word 255 written at addr 0xFF, ovf=1, state HALT, cpu_rstn never rises.
- ld_valid toggling 1/0 and abort asserted in RUN → writes only on valid cycles with contiguous addresses; abort returns IDLE next cycle and cycle_count holds.
- rstn low mid-LOAD, then start → all outputs at reset values; the next load restarts at addr 0.

Source files
------------

// File: rtl/xgriscv_run_ctrl.sv
// Run/halt sequencer for the xgriscv_sc core: streams a program into imem,
// holds the core in reset, lets it run, and reports how the run ended.
module xgriscv_run_ctrl #(
    parameter int                  ADDR_SIZE  = 32,
    parameter int                  IMEM_AW    = 8,
    parameter logic [ADDR_SIZE-1:0] HALT_PC   = 32'h80000078,
    parameter int                  MAX_CYCLES = 100,
    parameter int                  RESET_HOLD = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 ld_valid,
    input  logic [ADDR_SIZE-1:0] ld_data,
    input  logic                 ld_last,
    output logic                 ld_ready,
    output logic                 imem_we,
    output logic [IMEM_AW-1:0]   imem_waddr,
    output logic [ADDR_SIZE-1:0] imem_wdata,
    output logic                 cpu_rstn,
    input  logic [ADDR_SIZE-1:0] cpu_pc,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic                 ovf,
    output logic [ADDR_SIZE-1:0] final_pc,
    output logic [31:0]          cycle_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    localparam int                 HOLD_W   = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(RESET_HOLD - 1);
    localparam logic [IMEM_AW-1:0] WCNT_MAX  = '1;
    localparam logic [31:0]        CYC_LIMIT = 32'(MAX_CYCLES);

    logic [2:0]           state_q, state_d;
    logic [IMEM_AW-1:0]   wcnt_q, wcnt_d;
    logic [HOLD_W-1:0]    hcnt_q, hcnt_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic                 ovf_q, ovf_d;
    logic [ADDR_SIZE-1:0] final_pc_q, final_pc_d;
    logic [31:0]          cyc_q, cyc_d;

    assign ld_ready   = (state_q == S_LOAD);
    assign imem_we    = ld_ready && ld_valid;
    assign imem_waddr = wcnt_q;
    assign imem_wdata = imem_we ? ld_data : '0;
    assign cpu_rstn   = (state_q == S_RUN);
    assign busy       = (state_q == S_LOAD) || (state_q == S_HOLD) || (state_q == S_RUN);

    assign done        = done_q;
    assign timeout     = timeout_q;
    assign ovf         = ovf_q;
    assign final_pc    = final_pc_q;
    assign cycle_count = cyc_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        hcnt_d     = hcnt_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        ovf_d      = ovf_q;
        final_pc_d = final_pc_q;
        cyc_d      = cyc_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        done_d     = 1'b0;
                        timeout_d  = 1'b0;
                        ovf_d      = 1'b0;
                        cyc_d      = '0;
                        final_pc_d = '0;
                        wcnt_d     = '0;
                        state_d    = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        // The word counter saturates at the top address instead of wrapping.
                        if (wcnt_q != WCNT_MAX) begin
                            wcnt_d = wcnt_q + 1'b1;
                        end
                        if (ld_last) begin
                            hcnt_d  = HOLD_INIT;
                            state_d = S_HOLD;
                        end else if (wcnt_q == WCNT_MAX) begin
                            ovf_d      = 1'b1;
                            final_pc_d = '0;
                            state_d    = S_HALT;
                        end
                    end
                end
                S_HOLD: begin
                    if (hcnt_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        hcnt_d = hcnt_q - 1'b1;
                    end
                end
                S_RUN: begin
                    cyc_d = cyc_q + 32'd1;
                    if (cpu_pc == HALT_PC) begin
                        done_d     = 1'b1;
                        final_pc_d = cpu_pc;
                        state_d    = S_HALT;
                    end else if (cyc_q + 32'd1 == CYC_LIMIT) begin
                        timeout_d  = 1'b1;
                        final_pc_d = cpu_pc;
                        state_d    = S_HALT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            hcnt_q     <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ovf_q      <= 1'b0;
            final_pc_q <= '0;
            cyc_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            hcnt_q     <= hcnt_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            ovf_q      <= ovf_d;
            final_pc_q <= final_pc_d;
            cyc_q      <= cyc_d;
        end
    end

endmodule

// File: tb/tb_xgriscv_run_ctrl.sv
// Bench for xgriscv_run_ctrl: table of run scenarios, directed corner cases,
// and randomized load/run rounds checked against a sequence-level model.
module tb_xgriscv_run_ctrl;

    localparam int          ADDR_SIZE  = 32;
    localparam int          IMEM_AW    = 8;
    localparam logic [31:0] HALT_PC    = 32'h80000078;
    localparam int          MAX_CYCLES = 100;
    localparam int          RESET_HOLD = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, abort;
    logic        ld_valid, ld_last;
    logic [31:0] ld_data;
    logic        ld_ready, imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rstn;
    logic [31:0] cpu_pc;
    logic        busy, done, timeout, ovf;
    logic [31:0] final_pc, cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] prog [0:299];

    typedef struct {
        logic [31:0] base;
        logic [31:0] step;
        int          halt_step;
        bit          exp_done;
        bit          exp_to;
        int          exp_cnt;
        logic [31:0] exp_pc;
    } run_vec_t;

    run_vec_t vecs [6];

    xgriscv_run_ctrl #(
        .ADDR_SIZE (ADDR_SIZE),
        .IMEM_AW   (IMEM_AW),
        .HALT_PC   (HALT_PC),
        .MAX_CYCLES(MAX_CYCLES),
        .RESET_HOLD(RESET_HOLD)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rstn   (cpu_rstn),
        .cpu_pc     (cpu_pc),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .ovf        (ovf),
        .final_pc   (final_pc),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pc_for(input logic [31:0] base, input logic [31:0] step,
                                           input int hs, input int i);
        return (i == hs) ? HALT_PC : base + step * 32'(i);
    endfunction

    // Scan the PC sequence the core would present: first HALT_PC hit wins, else the budget.
    task automatic model_run(input logic [31:0] base, input logic [31:0] step, input int hs,
                             output bit e_done, output bit e_to, output int e_cnt,
                             output logic [31:0] e_pc);
        e_done = 1'b0;
        e_to   = 1'b1;
        e_cnt  = MAX_CYCLES;
        e_pc   = pc_for(base, step, hs, MAX_CYCLES - 1);
        for (int i = 0; i < MAX_CYCLES; i++) begin
            if (pc_for(base, step, hs, i) == HALT_PC) begin
                e_done = 1'b1;
                e_to   = 1'b0;
                e_cnt  = i + 1;
                e_pc   = HALT_PC;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode: 0 = valid held, 1 = valid alternates 1/0, 2 = random valid
    task automatic load_words(input int n, input int mode, input bit use_last);
        int k = 0;
        int guard = 0;
        bit v;
        while (k < n && guard < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            ld_valid = v;
            ld_data  = prog[k];
            ld_last  = use_last && (k == n - 1);
            #1;
            check("ld_ready in LOAD", {31'b0, ld_ready}, 32'd1);
            check("imem_we", {31'b0, imem_we}, {31'b0, v});
            if (v) begin
                check("imem_waddr", {24'b0, imem_waddr}, 32'(k));
                check("imem_wdata", imem_wdata, prog[k]);
            end
            @(negedge clk);
            if (v) k++;
            guard++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = '0;
    endtask

    task automatic hold_phase();
        int h = 0;
        while (cpu_rstn !== 1'b1 && h < 20) begin
            if (busy !== 1'b1 || ld_ready !== 1'b0) begin
                check("busy/ld_ready during HOLD", {30'b0, busy, ld_ready}, 32'b10);
            end
            @(negedge clk);
            h++;
        end
        check("HOLD length", 32'(h), 32'(RESET_HOLD));
    endtask

    task automatic run_core(input logic [31:0] base, input logic [31:0] step, input int hs,
                            output int ncyc);
        ncyc = 0;
        while (cpu_rstn === 1'b1 && ncyc < MAX_CYCLES + 10) begin
            cpu_pc = pc_for(base, step, hs, ncyc);
            @(negedge clk);
            ncyc++;
        end
        cpu_pc = '0;
    endtask

    task automatic check_result(input string tag, input bit e_done, input bit e_to,
                                input int e_cnt, input logic [31:0] e_pc, input int ncyc);
        check({tag, " run cycles"}, 32'(ncyc), 32'(e_cnt));
        check({tag, " done"}, {31'b0, done}, {31'b0, e_done});
        check({tag, " timeout"}, {31'b0, timeout}, {31'b0, e_to});
        check({tag, " cycle_count"}, cycle_count, 32'(e_cnt));
        check({tag, " final_pc"}, final_pc, e_pc);
        check({tag, " busy/cpu_rstn after"}, {30'b0, busy, cpu_rstn}, 32'd0);
    endtask

    initial begin
        int          ncyc;
        bit          e_done, e_to;
        int          e_cnt;
        logic [31:0] e_pc;

        vecs[0] = '{32'h80000000, 32'd4, -1, 1'b1, 1'b0,  31, 32'h80000078};
        vecs[1] = '{32'h80000010, 32'd0, -1, 1'b0, 1'b1, 100, 32'h80000010};
        vecs[2] = '{32'h80001000, 32'd4,  0, 1'b1, 1'b0,   1, 32'h80000078};
        vecs[3] = '{32'h80001000, 32'd4, 99, 1'b1, 1'b0, 100, 32'h80000078};
        vecs[4] = '{32'h80001000, 32'd4, 98, 1'b1, 1'b0,  99, 32'h80000078};
        vecs[5] = '{32'h80001000, 32'd4, -1, 1'b0, 1'b1, 100, 32'h8000118C};

        prog[0] = 32'h00000013;
        prog[1] = 32'h00000013;
        prog[2] = 32'h0000006f;

        rstn = 1'b0; start = 1'b0; abort = 1'b0;
        ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0; cpu_pc = '0;
        #12;
        check("reset cpu_rstn", {31'b0, cpu_rstn}, 32'd0);
        check("reset busy/ready/we", {29'b0, busy, ld_ready, imem_we}, 32'd0);
        check("reset flags", {29'b0, done, timeout, ovf}, 32'd0);
        check("reset final_pc", final_pc, 32'd0);
        check("reset cycle_count", cycle_count, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("idle without start", {31'b0, busy}, 32'd0);

        // Table of run scenarios, each on the 3-word program
        foreach (vecs[i]) begin
            pulse_start();
            check("start clears flags", {29'b0, done, timeout, ovf}, 32'd0);
            check("start clears cycle_count", cycle_count, 32'd0);
            check("start clears final_pc", final_pc, 32'd0);
            load_words(3, 0, 1'b1);
            hold_phase();
            run_core(vecs[i].base, vecs[i].step, vecs[i].halt_step, ncyc);
            check_result($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_to,
                         vecs[i].exp_cnt, vecs[i].exp_pc, ncyc);
        end

        // HALT holds its results
        repeat (3) @(negedge clk);
        check("HALT holds timeout", {31'b0, timeout}, 32'd1);
        check("HALT holds cycle_count", cycle_count, 32'd100);
        check("HALT holds final_pc", final_pc, 32'h8000118C);

        // Reset in the middle of a load, then a fresh load starting at address 0
        for (int i = 0; i < 5; i++) prog[i] = 32'hA5A50000 + 32'(i);
        pulse_start();
        load_words(2, 0, 1'b0);
        ld_valid = 1'b1;
        ld_data  = 32'hDEADBEEF;
        rstn     = 1'b0;
        #1;
        check("midload reset we/ready/busy", {29'b0, imem_we, ld_ready, busy}, 32'd0);
        check("midload reset waddr", {24'b0, imem_waddr}, 32'd0);
        check("midload reset wdata", imem_wdata, 32'd0);
        check("midload reset cpu_rstn", {31'b0, cpu_rstn}, 32'd0);
        check("midload reset cycle_count", cycle_count, 32'd0);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_data  = '0;
        rstn     = 1'b1;
        pulse_start();
        load_words(3, 0, 1'b1);
        hold_phase();
        run_core(32'h80003000, 32'd4, 2, ncyc);
        check_result("after reset", 1'b1, 1'b0, 3, HALT_PC, ncyc);

        // Toggling valid, start ignored in RUN, then abort in RUN
        for (int i = 0; i < 6; i++) prog[i] = 32'h12340000 + 32'(i * 7);
        pulse_start();
        load_words(6, 1, 1'b1);
        hold_phase();
        for (int i = 0; i < 10; i++) begin
            cpu_pc = 32'h80002000 + 32'(4 * i);
            start  = (i == 5);
            @(negedge clk);
        end
        start = 1'b0;
        check("start ignored in RUN", {30'b0, busy, cpu_rstn}, 32'b11);
        check("cycle_count before abort", cycle_count, 32'd10);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort to IDLE", {30'b0, busy, cpu_rstn}, 32'd0);
        check("abort holds cycle_count", cycle_count, 32'd10);
        check("abort keeps flags", {30'b0, done, timeout}, 32'd0);
        repeat (3) @(negedge clk);
        check("IDLE after abort", {31'b0, busy}, 32'd0);
        check("cycle_count still held", cycle_count, 32'd10);

        // Overflow: 256 words without ld_last
        for (int i = 0; i < 256; i++) prog[i] = $urandom;
        pulse_start();
        load_words(256, 0, 1'b0);
        check("ovf set", {31'b0, ovf}, 32'd1);
        check("ovf no done/timeout", {30'b0, done, timeout}, 32'd0);
        check("ovf final_pc", final_pc, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("ovf stays halted", {29'b0, busy, cpu_rstn, ld_ready}, 32'd0);
            @(negedge clk);
        end

        // Randomized load/run rounds against the sequence model
        for (int r = 0; r < 8; r++) begin
            int          len, hs;
            logic [31:0] base, step;
            len  = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) prog[i] = $urandom;
            base = 32'h80000000 + 32'(4 * $urandom_range(0, 64));
            step = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'd4;
            hs   = $urandom_range(0, 130);
            pulse_start();
            load_words(len, 2, 1'b1);
            hold_phase();
            run_core(base, step, hs, ncyc);
            model_run(base, step, hs, e_done, e_to, e_cnt, e_pc);
            check_result($sformatf("rand%0d", r), e_done, e_to, e_cnt, e_pc, ncyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
